pixel_read_buffer: RTL and testbench

Avalon-MM read master with a pixel staging store that feeds the filter datapath under control of the controller FSM.
It fetches a 3-column x 8-row pixel window (24 pixels) from frame memory, then prefetches the next 8-pixel column into a pending buffer while the filter works.
On command it slides the window by one column.
It produces the done_read24, done_load_read_buffer and done_shift8 handshakes the controller consumes.

---
 rtl/pixel_read_pkg.sv | 28 ++
 rtl/avalon_read_issuer.sv | 76 +++++++
 rtl/pixel_read_buffer.sv | 151 +++++++++++++++
 tb/tb_pixel_read_buffer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_read_pkg.sv
// Shared constants and types for the pixel read buffer.
// PIX_W          : pixel width taken from the low bits of the Avalon read data
// WIN_COLS/ROWS  : window geometry (3 columns x 8 rows)
// WIN_SIZE       : number of pixels held in the window
// CNT_W          : width of the request/response counters (0..WIN_SIZE)
// state_t        : fetch FSM states
// dest_t         : which store a fetch fills
package pixel_read_pkg;

  localparam int unsigned PIX_W    = 24;
  localparam int unsigned WIN_COLS = 3;
  localparam int unsigned WIN_ROWS = 8;
  localparam int unsigned WIN_SIZE = WIN_COLS * WIN_ROWS;
  localparam int unsigned CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef enum logic {
    DST_WINDOW,
    DST_PENDING
  } dest_t;

endpackage

// File: rtl/avalon_read_issuer.sv
// Avalon-MM read request issuer for column-major pixel fetches.
// Owns the issued/received counters, the outstanding-read limit and the
// address generator.
//   start/start_target/base_addr : begin a fetch of start_target words
//   issue_en                     : requests may be issued (FSM in ISSUE)
//   rx_en                        : responses may be captured (ISSUE/DRAIN)
//   issue_done / rx_done         : all requests issued / all responses received
//   rx_valid / rx_index          : capture strobe and destination index
//   master_*                     : Avalon-MM read master signals
module avalon_read_issuer
  import pixel_read_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ROW_STRIDE = 640,
  parameter int unsigned MAX_PEND   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  start_target,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              issue_en,
  input  logic              rx_en,
  output logic              issue_done,
  output logic              rx_done,
  output logic              rx_valid,
  output logic [CNT_W-1:0]  rx_index,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic              master_waitrequest,
  input  logic              master_readdatavalid
);

  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(ROW_STRIDE);
  localparam logic [CNT_W-1:0]  PEND_LIMIT = CNT_W'(MAX_PEND);

  logic [CNT_W-1:0]  target;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  received;
  logic [CNT_W-1:0]  outstanding;
  logic [ADDR_W-1:0] base_q;
  logic              issue_fire;

  // Request k walks down a column first: low 3 bits select the row,
  // upper bits the column. The address only moves when a request is
  // accepted, so it is held stable across waitrequest stalls.
  always_comb begin
    outstanding    = issued - received;
    issue_done     = (issued == target);
    rx_done        = (received == target);
    master_read    = issue_en && (issued < target) && (outstanding < PEND_LIMIT);
    issue_fire     = master_read && !master_waitrequest;
    rx_valid       = rx_en && master_readdatavalid && (received < target);
    rx_index       = received;
    master_address = base_q + ADDR_W'(issued[2:0]) * STRIDE
                   + ADDR_W'(issued[CNT_W-1:3]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target   <= '0;
      issued   <= '0;
      received <= '0;
      base_q   <= '0;
    end else if (start) begin
      target   <= start_target;
      issued   <= '0;
      received <= '0;
      base_q   <= base_addr;
    end else begin
      if (issue_fire) issued   <= issued + CNT_W'(1);
      if (rx_valid)   received <= received + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pixel_read_buffer.sv
// Pixel staging store with Avalon-MM read master for the filter datapath.
// Fetches a 3x8 pixel window, prefetches the next column into a pending
// buffer, and slides the window by one column on command.
//   load24 / load8 / shift_enable8 : command pulses from the controller
//   base_addr                      : top pixel address, sampled on a load
//   win_sel / win_pixel            : combinational window read port
//   done_read24, done_shift8       : single-cycle completion pulses
//   done_load_read_buffer          : pending column valid (level)
//   busy, shift_err                : fetch in progress / sticky misuse flag
//   master_*                       : Avalon-MM read master
module pixel_read_buffer
  import pixel_read_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ROW_STRIDE = 640,
  parameter int unsigned MAX_PEND   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load24,
  input  logic              load8,
  input  logic              shift_enable8,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [4:0]        win_sel,
  output logic [PIX_W-1:0]  win_pixel,
  output logic              done_read24,
  output logic              done_load_read_buffer,
  output logic              done_shift8,
  output logic              busy,
  output logic              shift_err,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  input  logic              master_waitrequest,
  input  logic [31:0]       master_readdata,
  input  logic              master_readdatavalid
);

  state_t           state, state_nxt;
  dest_t            dest;
  logic [PIX_W-1:0] window  [WIN_SIZE];
  logic [PIX_W-1:0] pending [WIN_ROWS];
  logic             pend_valid;
  logic             shift_q;
  logic             err_q;
  logic             accept24, accept8, shift_ok, bad_req;
  logic             issue_en, rx_en;
  logic             issue_done, rx_done, rx_valid;
  logic [CNT_W-1:0] rx_index;
  logic             unused_readdata_hi;

  assign unused_readdata_hi = ^master_readdata[31:PIX_W];

  avalon_read_issuer #(
    .ADDR_W     (ADDR_W),
    .ROW_STRIDE (ROW_STRIDE),
    .MAX_PEND   (MAX_PEND)
  ) u_issuer (
    .clk                  (clk),
    .rst                  (rst),
    .start                (accept24 || accept8),
    .start_target         (accept24 ? CNT_W'(WIN_SIZE) : CNT_W'(WIN_ROWS)),
    .base_addr            (base_addr),
    .issue_en             (issue_en),
    .rx_en                (rx_en),
    .issue_done           (issue_done),
    .rx_done              (rx_done),
    .rx_valid             (rx_valid),
    .rx_index             (rx_index),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_waitrequest   (master_waitrequest),
    .master_readdatavalid (master_readdatavalid)
  );

  // Command decode: commands are only honoured in IDLE; load24 wins over load8.
  always_comb begin
    accept24 = (state == IDLE) && load24;
    accept8  = (state == IDLE) && load8 && !load24;
    shift_ok = (state == IDLE) && shift_enable8 && pend_valid;
    bad_req  = (shift_enable8 && !shift_ok) || ((state != IDLE) && (load24 || load8));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept24 || accept8) state_nxt = ISSUE;
      ISSUE:   if (issue_done)          state_nxt = DRAIN;
      DRAIN:   if (rx_done)             state_nxt = DONE;
      DONE:                             state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    issue_en    = (state == ISSUE);
    rx_en       = (state == ISSUE) || (state == DRAIN);
    done_read24 = (state == DONE) && (dest == DST_WINDOW);
  end

  assign done_load_read_buffer = pend_valid;
  assign done_shift8           = shift_q;
  assign shift_err             = err_q;

  always_comb begin
    win_pixel = '0;
    if (win_sel < 5'(WIN_SIZE)) win_pixel = window[win_sel];
  end

  // pend_valid is set on the DRAIN->DONE edge so that it rises together
  // with the DONE cycle, matching the done_read24 timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      dest       <= DST_WINDOW;
      pend_valid <= 1'b0;
      shift_q    <= 1'b0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < WIN_SIZE; i++) window[i]  <= '0;
      for (int unsigned i = 0; i < WIN_ROWS; i++) pending[i] <= '0;
    end else begin
      shift_q <= shift_ok;
      if (bad_req) err_q <= 1'b1;

      if (accept24)     dest <= DST_WINDOW;
      else if (accept8) dest <= DST_PENDING;

      if (shift_ok) begin
        for (int unsigned i = 0; i < WIN_SIZE - WIN_ROWS; i++)
          window[i] <= window[i + WIN_ROWS];
        for (int unsigned i = 0; i < WIN_ROWS; i++)
          window[WIN_SIZE - WIN_ROWS + i] <= pending[i];
      end

      if (rx_valid) begin
        if (dest == DST_WINDOW) window[rx_index] <= master_readdata[PIX_W-1:0];
        else                    pending[rx_index[2:0]] <= master_readdata[PIX_W-1:0];
      end

      if (accept8 || shift_ok)
        pend_valid <= 1'b0;
      else if ((state == DRAIN) && rx_done && (dest == DST_PENDING))
        pend_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_read_buffer.sv
module tb_pixel_read_buffer;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned ROW_STRIDE = 640;
  localparam int unsigned MAX_PEND   = 4;

  logic        clk = 1'b0;
  logic        rst, load24, load8, shift_enable8;
  logic [31:0] base_addr;
  logic [4:0]  win_sel;
  logic [23:0] win_pixel;
  logic        done_read24, done_load_read_buffer, done_shift8, busy, shift_err;
  logic [31:0] master_address;
  logic        master_read, master_waitrequest, master_readdatavalid;
  logic [31:0] master_readdata;

  always #5 clk = ~clk;

  pixel_read_buffer #(
    .ADDR_W     (ADDR_W),
    .ROW_STRIDE (ROW_STRIDE),
    .MAX_PEND   (MAX_PEND)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .load24                (load24),
    .load8                 (load8),
    .shift_enable8         (shift_enable8),
    .base_addr             (base_addr),
    .win_sel               (win_sel),
    .win_pixel             (win_pixel),
    .done_read24           (done_read24),
    .done_load_read_buffer (done_load_read_buffer),
    .done_shift8           (done_shift8),
    .busy                  (busy),
    .shift_err             (shift_err),
    .master_address        (master_address),
    .master_read           (master_read),
    .master_waitrequest    (master_waitrequest),
    .master_readdata       (master_readdata),
    .master_readdatavalid  (master_readdatavalid)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory slave configuration and observation state
  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;
  req_t        rq[$];
  logic [31:0] addr_log[$];
  int          lat = 1;
  bit          stall_mode = 1'b0;
  bit          seq_mode = 1'b1;
  logic [31:0] seq_base = 32'h100;
  logic [31:0] salt;
  int rsp_seq = 0, acc_op = 0, acc_total = 0, rsp_total = 0, last_rdv_cyc = 0;
  int n_done24 = 0, done24_cyc = 0, n_shift8 = 0, shift8_cyc = 0, lrb_rise_cyc = 0;
  int max_out = 0, stab_err = 0, stall_events = 0;
  bit prev_lrb = 1'b0, prev_stalled = 1'b0;
  logic [31:0] prev_addr = '0;

  logic [23:0] exp_win  [24];
  logic [23:0] exp_pend [8];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ salt;
  endfunction

  function automatic logic [23:0] pix_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return w[23:0];
  endfunction

  // Avalon slave: in-order responses a fixed latency after acceptance,
  // optional alternating waitrequest; also monitors the DUT handshakes.
  initial begin
    req_t r;
    logic w;
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
    forever begin
      @(negedge clk);
      if (done_read24) begin n_done24++; done24_cyc = cyc; end
      if (done_shift8) begin n_shift8++; shift8_cyc = cyc; end
      if (done_load_read_buffer && !prev_lrb) lrb_rise_cyc = cyc;
      prev_lrb = done_load_read_buffer;
      if (prev_stalled && stall_mode) begin
        stall_events++;
        if (!master_read || master_address !== prev_addr) stab_err++;
      end
      master_readdatavalid = 1'b0;
      master_readdata      = $urandom;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        master_readdatavalid = 1'b1;
        if (seq_mode) begin
          master_readdata        = seq_base + 32'(rsp_seq);
          master_readdata[31:24] = 8'($urandom);
        end else begin
          master_readdata = mem_word(r.addr);
        end
        rsp_seq++;
        rsp_total++;
        last_rdv_cyc = cyc;
      end
      w = stall_mode ? !master_waitrequest : 1'b0;
      master_waitrequest = w;
      prev_stalled = master_read && w;
      prev_addr    = master_address;
      if (master_read && !w) begin
        rq.push_back('{master_address, cyc + lat});
        addr_log.push_back(master_address);
        acc_total++;
        acc_op++;
      end
      if (acc_total - rsp_total > max_out) max_out = acc_total - rsp_total;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_window(input string tag);
    for (int i = 0; i < 24; i++) begin
      win_sel = 5'(i);
      #1;
      chk($sformatf("%s win[%0d]", tag, i), 32'(win_pixel), 32'(exp_win[i]));
    end
  endtask

  task automatic check_addrs(input string tag, input logic [31:0] base, input int n);
    chk({tag, " request count"}, 32'(addr_log.size()), 32'(n));
    for (int k = 0; k < n && k < addr_log.size(); k++)
      chk($sformatf("%s addr[%0d]", tag, k), addr_log[k],
          base + 32'((k % 8) * ROW_STRIDE) + 32'(k / 8));
  endtask

  task automatic model_load24(input logic [31:0] base);
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 8; r++)
        exp_win[c*8 + r] = seq_mode ? 24'(seq_base + 32'(c*8 + r))
                                    : pix_at(base + 32'(r * ROW_STRIDE) + 32'(c));
  endtask

  task automatic model_load8(input logic [31:0] base);
    for (int r = 0; r < 8; r++)
      exp_pend[r] = seq_mode ? 24'(seq_base + 32'(r)) : pix_at(base + 32'(r * ROW_STRIDE));
  endtask

  task automatic model_shift();
    for (int i = 0; i < 16; i++) exp_win[i] = exp_win[i + 8];
    for (int r = 0; r < 8; r++)  exp_win[16 + r] = exp_pend[r];
  endtask

  task automatic start_op(input bit is24, input logic [31:0] base);
    @(negedge clk);
    rsp_seq = 0;
    acc_op  = 0;
    addr_log.delete();
    base_addr = base;
    if (is24) load24 = 1'b1;
    else      load8  = 1'b1;
    @(negedge clk);
    load24 = 1'b0;
    load8  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " idle timeout"}, 32'(busy), 32'(0));
  endtask

  task automatic pulse_shift();
    @(negedge clk);
    shift_enable8 = 1'b1;
    @(negedge clk);
    shift_enable8 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n0, s, n, rsp_before;
    bit found;
    logic [31:0] b;
    salt = $urandom;
    rst = 1'b1; load24 = 1'b0; load8 = 1'b0; shift_enable8 = 1'b0;
    base_addr = '0; win_sel = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst done_read24", 32'(done_read24), 32'(0));
    chk("rst done_lrb", 32'(done_load_read_buffer), 32'(0));
    chk("rst done_shift8", 32'(done_shift8), 32'(0));
    chk("rst shift_err", 32'(shift_err), 32'(0));
    chk("rst master_read", 32'(master_read), 32'(0));
    chk("rst master_address", master_address, 32'(0));
    for (int i = 0; i < 24; i++) exp_win[i] = '0;
    check_window("rst");
    rst = 1'b0;

    // A: full window, no stalls, one-cycle response latency
    seq_mode = 1'b1; seq_base = 32'h100; lat = 1; stall_mode = 1'b0;
    n0 = n_done24;
    start_op(1'b1, 32'd1000);
    wait_idle("A");
    model_load24(32'd1000);
    chk("A done24 count", 32'(n_done24 - n0), 32'(1));
    chk("A done24 latency", 32'(done24_cyc - last_rdv_cyc), 32'(2));
    check_addrs("A", 32'd1000, 24);
    check_window("A");
    win_sel = 5'd9;  #1; chk("A win_sel 9", 32'(win_pixel), 32'h109);
    win_sel = 5'd24; #1; chk("A win_sel 24", 32'(win_pixel), 32'(0));
    win_sel = 5'd31; #1; chk("A win_sel 31", 32'(win_pixel), 32'(0));
    chk("A shift_err", 32'(shift_err), 32'(0));
    chk("A done_lrb", 32'(done_load_read_buffer), 32'(0));

    // B: same fetch with alternating stalls and 5-cycle responses
    lat = 5; stall_mode = 1'b1; max_out = 0; stab_err = 0; stall_events = 0;
    n0 = n_done24;
    start_op(1'b1, 32'd1000);
    wait_idle("B");
    stall_mode = 1'b0;
    chk("B outstanding limit", 32'(max_out <= int'(MAX_PEND)), 32'(1));
    chk("B stalls seen", 32'(stall_events > 0), 32'(1));
    chk("B stall stability", 32'(stab_err), 32'(0));
    chk("B done24 count", 32'(n_done24 - n0), 32'(1));
    check_addrs("B", 32'd1000, 24);
    check_window("B");

    // C: load8 then a legal shift
    seq_base = 32'hA0; lat = 2;
    n0 = n_done24;
    start_op(1'b0, 32'd2000);
    wait_idle("C");
    model_load8(32'd2000);
    check_addrs("C", 32'd2000, 8);
    chk("C done_lrb set", 32'(done_load_read_buffer), 32'(1));
    chk("C done_lrb latency", 32'(lrb_rise_cyc - last_rdv_cyc), 32'(2));
    chk("C no done24", 32'(n_done24 - n0), 32'(0));
    repeat (3) @(negedge clk);
    chk("C done_lrb held", 32'(done_load_read_buffer), 32'(1));
    n0 = n_shift8;
    @(negedge clk);
    s = cyc;
    shift_enable8 = 1'b1;
    @(negedge clk);
    shift_enable8 = 1'b0;
    @(negedge clk);
    model_shift();
    chk("C done_shift8 count", 32'(n_shift8 - n0), 32'(1));
    chk("C done_shift8 timing", 32'(shift8_cyc), 32'(s + 1));
    chk("C done_lrb cleared", 32'(done_load_read_buffer), 32'(0));
    chk("C shift_err", 32'(shift_err), 32'(0));
    win_sel = 5'd16; #1; chk("C win_sel 16", 32'(win_pixel), 32'hA0);
    check_window("C");

    // D: load8 while busy is ignored and flagged
    seq_mode = 1'b0; lat = 3;
    b = $urandom;
    start_op(1'b1, b);
    repeat (3) @(negedge clk);
    chk("D busy during fetch", 32'(busy), 32'(1));
    load8 = 1'b1;
    @(negedge clk);
    load8 = 1'b0;
    wait_idle("D");
    model_load24(b);
    chk("D shift_err", 32'(shift_err), 32'(1));
    chk("D load8 ignored", 32'(done_load_read_buffer), 32'(0));
    check_window("D");

    // E: shift with no pending column
    n0 = n_shift8;
    pulse_shift();
    chk("E no done_shift8", 32'(n_shift8 - n0), 32'(0));
    chk("E shift_err sticky", 32'(shift_err), 32'(1));
    check_window("E");

    // F: shift landing on the DONE cycle of a load8 is refused
    lat = 1;
    b = $urandom;
    n0 = n_shift8;
    start_op(1'b0, b);
    found = 1'b0;
    n = 0;
    while (!found && n < 500) begin
      if (busy && done_load_read_buffer) found = 1'b1;
      else begin @(negedge clk); n++; end
    end
    chk("F done cycle found", 32'(found), 32'(1));
    shift_enable8 = 1'b1;
    @(negedge clk);
    shift_enable8 = 1'b0;
    wait_idle("F");
    @(negedge clk);
    model_load8(b);
    chk("F no done_shift8", 32'(n_shift8 - n0), 32'(0));
    chk("F pending still valid", 32'(done_load_read_buffer), 32'(1));
    check_window("F pre");
    pulse_shift();
    model_shift();
    chk("F shift honoured", 32'(n_shift8 - n0), 32'(1));
    check_window("F post");

    // G: randomized load24 / load8 / shift sequences
    for (int it = 0; it < 3; it++) begin
      lat = int'($urandom_range(1, 6));
      stall_mode = 1'($urandom_range(0, 1));
      b = $urandom;
      n0 = n_done24;
      start_op(1'b1, b);
      wait_idle("G24");
      model_load24(b);
      chk($sformatf("G%0d done24 count", it), 32'(n_done24 - n0), 32'(1));
      b = $urandom;
      start_op(1'b0, b);
      wait_idle("G8");
      model_load8(b);
      pulse_shift();
      model_shift();
      stall_mode = 1'b0;
      check_window($sformatf("G%0d", it));
    end

    // H: reset in the middle of a window fetch
    lat = 4;
    b = $urandom;
    start_op(1'b1, b);
    n = 0;
    while (acc_op < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("H ten issued", 32'(acc_op >= 10), 32'(1));
    rst = 1'b1;
    rsp_before = rsp_total;
    @(negedge clk);
    chk("H master_read", 32'(master_read), 32'(0));
    chk("H busy", 32'(busy), 32'(0));
    chk("H done_read24", 32'(done_read24), 32'(0));
    chk("H done_lrb", 32'(done_load_read_buffer), 32'(0));
    chk("H done_shift8", 32'(done_shift8), 32'(0));
    chk("H shift_err", 32'(shift_err), 32'(0));
    chk("H master_address", master_address, 32'(0));
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("H orphans delivered", 32'(rsp_total - rsp_before > 0), 32'(1));
    chk("H idle after orphans", 32'(busy), 32'(0));
    for (int i = 0; i < 24; i++) exp_win[i] = '0;
    check_window("H cleared");
    lat = 1;
    b = $urandom;
    n0 = n_done24;
    start_op(1'b1, b);
    wait_idle("H reload");
    model_load24(b);
    chk("H reload done24", 32'(n_done24 - n0), 32'(1));
    check_window("H reload");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
